r4_stage_ctrl: RTL
==================

R4_STAGE_CTRL -- requirements
Module: r4_stage_ctrl

Interface
REQ-001 SHALL have parameter N_LOG4, default 2, meaning transform size N = 4^N_LOG4 points and AW = 2*N_LOG4 address bits.
REQ-002 SHALL have parameter BF_LATENCY, default 4, meaning cycles from butterfly input valid to butterfly output valid.
REQ-003 SHALL have ports, one per line:
 clk  in  1  system clock
 reset  in  1  synchronous, active-high reset
 start  in  1  begin one radix-4 stage pass
 stage  in  N_LOG4 bits (min 1)  stage index s, sampled when start is accepted
 busy  out  1  pass in progress
 done  out  1  one-cycle pulse at pass completion
 rd_en  out  1  sample RAM read strobe, all four legs
 rd_addr  out  4*AW  read addresses, leg k in bits [k*AW +: AW]
 bf_valid  out  1  butterfly inputs valid (rd_en delayed 1 cycle)
 wr_en  out  1  result write strobe
 wr_addr  out  4*AW  write addresses, same leg packing as rd_addr
 tw_idx  out  AW  twiddle base index (present only with R4_CTRL_TWIDDLE_EN)

Function
REQ-004 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-005 IDLE: start=1 SHALL latch stage, clear counters, go to ISSUE next cycle; start ignored in every other state.
REQ-006 stride SHALL be 4^(N_LOG4-1-s); stage values >= N_LOG4 SHALL be treated as N_LOG4-1.
REQ-007 ISSUE: one butterfly per cycle, b = 0..N/4-1; rd_en=1 every ISSUE cycle.
REQ-008 For butterfly b: offset = b mod stride, group = b div stride, base = group*4*stride + offset; leg k address = base + k*stride, k = 0..3.
REQ-009 Address generation SHALL use an offset counter wrapping at stride-1 and a group base incrementing by 4*stride; no divider or multiplier.
REQ-010 After issuing b = N/4-1, SHALL go to DRAIN.
REQ-011 bf_valid SHALL equal rd_en delayed exactly 1 cycle (synchronous RAM read latency).
REQ-012 wr_en and wr_addr SHALL equal rd_en and rd_addr delayed exactly 1+BF_LATENCY cycles through a shift register (in-place write-back).
REQ-013 DRAIN: SHALL wait until the last wr_en has been emitted, then go to DONE.
REQ-014 DONE: done=1 for exactly one cycle, then IDLE.
REQ-015 busy SHALL be 1 in ISSUE, DRAIN and DONE, 0 in IDLE.
REQ-016 rd_addr SHALL hold its last value when rd_en=0; wr_addr likewise when wr_en=0.
REQ-017 start asserted in the DONE cycle SHALL be ignored; a new pass requires start in IDLE.

Reset
REQ-018 reset=1 SHALL force IDLE, clear all counters and delay-line valid bits, regardless of state.
REQ-019 After reset: busy=0, done=0, rd_en=0, bf_valid=0, wr_en=0, rd_addr=0, wr_addr=0, tw_idx=0.
REQ-020 Reset mid-pass SHALL abort the pass: no further wr_en, no done pulse.

Configuration
REQ-021 With macro R4_CTRL_TWIDDLE_EN defined, tw_idx SHALL be offset * 4^s (offset shifted left by 2*s), aligned with bf_valid; consumer forms leg k twiddle as W_N^(k*tw_idx).
REQ-022 Without R4_CTRL_TWIDDLE_EN, the tw_idx port and its logic SHALL be absent; all other behaviour identical.

Verification (N_LOG4=2, BF_LATENCY=4, start accepted at cycle T)
REQ-023 stage=0 -> rd_en high T+1..T+4; rd_addr legs (0,4,8,12),(1,5,9,13),(2,6,10,14),(3,7,11,15).
REQ-024 stage=1 -> rd_addr legs (0,1,2,3),(4,5,6,7),(8,9,10,11),(12,13,14,15); tw_idx 0 each cycle (with macro).
REQ-025 stage=0 -> bf_valid T+2..T+5, wr_en T+6..T+9 with wr_addr matching REQ-023 order, done pulse T+10, busy 1 T+1..T+10, 0 at T+11.
REQ-026 start held high through a pass -> second pass starts only after IDLE at T+11; no overlapping rd_en.
REQ-027 reset at T+7 during stage=0 pass -> wr_en 0 from T+8 on, no done, busy 0 at T+8.
REQ-028 With macro, stage=0 -> tw_idx 0,1,2,3 aligned with bf_valid T+2..T+5.

Source files
------------

// File: rtl/r4_stage_ctrl.sv
// Radix-4 stage controller: sequences the reads, butterfly timing and in-place write-back of one FFT stage pass.
// Define R4_CTRL_TWIDDLE_EN to add the tw_idx twiddle base output.
module r4_stage_ctrl #(
  parameter int N_LOG4     = 2,
  parameter int BF_LATENCY = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [((N_LOG4 > 1) ? N_LOG4 : 1)-1:0] stage,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [8*N_LOG4-1:0]                   rd_addr,
  output logic                                  bf_valid,
  output logic                                  wr_en,
  output logic [8*N_LOG4-1:0]                   wr_addr
`ifdef R4_CTRL_TWIDDLE_EN
  ,
  output logic [2*N_LOG4-1:0]                   tw_idx
`endif
);

  localparam int AW = 2 * N_LOG4;
  localparam int SW = (N_LOG4 > 1) ? N_LOG4 : 1;
  localparam int NB = 1 << (AW - 2);
  localparam int D  = 1 + BF_LATENCY;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   s_eff;
  logic [AW-1:0]   stride_in, stride, off, gbase, bcnt, nxt_off, nxt_gbase;
  logic            accept, last_b, off_wrap, drain_clear;
  logic [D-1:0]    vld_pipe;
  logic [4*AW-1:0] addr_pipe [D];

  // Leg addresses base + k*stride built from adds only.
  function automatic logic [4*AW-1:0] legs(input logic [AW-1:0] base, input logic [AW-1:0] st);
    logic [AW-1:0] st2;
    st2 = st << 1;
    return {base + st2 + st, base + st2, base + st, base};
  endfunction

  always_comb begin
    s_eff     = (int'(stage) >= N_LOG4) ? SW'(N_LOG4 - 1) : stage;
    stride_in = AW'(1) << (2 * (N_LOG4 - 1 - int'(s_eff)));
  end

  always_comb begin
    accept    = (state == S_IDLE) && start;
    last_b    = (bcnt == AW'(NB - 1));
    off_wrap  = (off == stride - 1'b1);
    nxt_off   = off_wrap ? '0 : off + 1'b1;
    nxt_gbase = off_wrap ? gbase + (stride << 2) : gbase;
    // Drain is complete once only the final delay stage may still hold a write.
    drain_clear = 1'b1;
    for (int i = 0; i < D - 1; i++) begin
      if (vld_pipe[i]) drain_clear = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        if (last_b) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_clear) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // rd_addr is preloaded with butterfly 0 on accept, then advanced one butterfly per issue cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stride  <= '0;
      off     <= '0;
      gbase   <= '0;
      bcnt    <= '0;
      rd_addr <= '0;
    end else if (accept) begin
      stride  <= stride_in;
      off     <= '0;
      gbase   <= '0;
      bcnt    <= '0;
      rd_addr <= legs('0, stride_in);
    end else if (state == S_ISSUE && !last_b) begin
      off     <= nxt_off;
      gbase   <= nxt_gbase;
      bcnt    <= bcnt + 1'b1;
      rd_addr <= legs(nxt_gbase + nxt_off, stride);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bf_valid <= 1'b0;
      vld_pipe <= '0;
      for (int i = 0; i < D; i++) addr_pipe[i] <= '0;
    end else begin
      bf_valid    <= rd_en;
      vld_pipe[0] <= rd_en;
      if (rd_en) addr_pipe[0] <= rd_addr;
      for (int i = 1; i < D; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign wr_en   = vld_pipe[D-1];
  assign wr_addr = addr_pipe[D-1];

`ifdef R4_CTRL_TWIDDLE_EN
  logic [SW-1:0] s_q;
  logic [AW-1:0] tw_rd;

  // tw_rd tracks rd_addr; tw_idx lags it one cycle to line up with bf_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= '0;
      tw_rd  <= '0;
      tw_idx <= '0;
    end else begin
      if (accept) begin
        s_q   <= s_eff;
        tw_rd <= '0;
      end else if (state == S_ISSUE && !last_b) begin
        tw_rd <= nxt_off << (2 * s_q);
      end
      if (rd_en) tw_idx <= tw_rd;
    end
  end
`endif

endmodule
